// File: rtl/reduce_nway.sv
// Packet reducer: folds every beat of a packet into one lane word (OR/AND/XOR) and a 1-bit reduction.
// Define REDUCE_NWAY_XOR_EN to build XOR support for mode 2'b10; otherwise that mode folds as OR.
module reduce_nway #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_last,
  input  logic [1:0]                       mode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_lane,
  output logic                             out_data,
  output logic [$clog2(MAX_BEATS+1)-1:0]   out_beats,
  output logic                             out_overflow
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       mode_q, mode_d;
  logic             red_d;
  logic [WIDTH-1:0] out_lane_q;
  logic             out_data_q;
  logic [CW-1:0]    out_beats_q;
  logic             out_ovf_q;

  assign in_ready     = (state_q != DONE);
  assign out_valid    = (state_q == DONE);
  assign out_lane     = out_lane_q;
  assign out_data     = out_data_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_ovf_q;

  // First beat seeds the accumulator and latches the mode; later beats fold in with the latched mode.
  always_comb begin
    acc_d   = in_data;
    count_d = CW'(1);
    ovf_d   = 1'b0;
    mode_d  = mode;
    if (state_q == ACC) begin
      mode_d = mode_q;
      if (count_q == CW'(MAX_BEATS)) begin
        count_d = count_q;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
        ovf_d   = ovf_q;
      end
      case (mode_q)
        2'b01:   acc_d = acc_q & in_data;
`ifdef REDUCE_NWAY_XOR_EN
        2'b10:   acc_d = acc_q ^ in_data;
`endif
        default: acc_d = acc_q | in_data;
      endcase
    end
    case (mode_d)
      2'b01:   red_d = &acc_d;
`ifdef REDUCE_NWAY_XOR_EN
      2'b10:   red_d = ^acc_d;
`endif
      default: red_d = |acc_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      mode_q      <= 2'b00;
      out_lane_q  <= '0;
      out_data_q  <= 1'b0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (in_valid && in_ready) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
            if (in_last) begin
              // Result registers only change here, so they stay frozen through DONE back-pressure.
              state_q     <= DONE;
              out_lane_q  <= acc_d;
              out_data_q  <= red_d;
              out_beats_q <= count_d;
              out_ovf_q   <= ovf_d;
            end else begin
              state_q <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
